// File: rtl/vga_scan_gen.sv
// 640x480@60 raster timing generator: pixel-rate divider, h/v counters, registered syncs.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_scan_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pixel_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
`ifdef VGA_FRAME_CNT_EN
  output logic [7:0] frame_cnt,
`endif
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [4:0] DIV_LAST  = 5'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_DISP);
  localparam logic [9:0] V_VIS     = 10'(V_DISP);
  localparam logic [9:0] HS_START  = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_DISP + V_FP + V_SYNC);

  logic [4:0] div_q, div_d;
  logic       tick_q, tick_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       valid_q, valid_d;
  logic       fstart_q, fstart_d;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;
`endif

  // Syncs and valid are decoded from next-state counters so they move on the same edge.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? 5'd0 : div_q + 5'd1;
    tick_d   = (div_q == DIV_LAST);
    h_d      = h_q;
    v_d      = v_q;
    fstart_d = 1'b0;
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        if (v_q == V_LAST) begin
          v_d      = 10'd0;
          fstart_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    hsync_d = !((h_d >= HS_START) && (h_d < HS_END));
    vsync_d = !((v_d >= VS_START) && (v_d < VS_END));
    valid_d = (h_d < H_VIS) && (v_d < V_VIS);
`ifdef VGA_FRAME_CNT_EN
    fcnt_d  = fcnt_q + {7'd0, fstart_q};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q    <= 5'd0;
      tick_q   <= 1'b0;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      valid_q  <= 1'b0;
      fstart_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      fcnt_q   <= 8'd0;
`endif
    end else begin
      div_q    <= div_d;
      tick_q   <= tick_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      valid_q  <= valid_d;
      fstart_q <= fstart_d;
`ifdef VGA_FRAME_CNT_EN
      fcnt_q   <= fcnt_d;
`endif
    end
  end

  assign pixel_tick  = tick_q;
  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign frame_start = fstart_q;
`ifdef VGA_FRAME_CNT_EN
  assign frame_cnt   = fcnt_q;
`endif

endmodule
